// File: rtl/ap_pkg.sv
// ---------------------------------------------------------------------------
// ap_pkg
// Shared definitions for the associative-processor match resolver and the
// CAM array it reads from.
//   state_t            : resolver walk states (IDLE, SCAN, READ, DONE)
//   RowxRow .. COPY_A  : array input_mode encodings, shared with the array
// ---------------------------------------------------------------------------
package ap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] RowxRow = 3'd1;
  localparam logic [2:0] ColxCol = 3'd2;
  localparam logic [2:0] COPY_B  = 3'd3;
  localparam logic [2:0] COPY_R  = 3'd4;
  localparam logic [2:0] COPY_A  = 3'd5;

endpackage

// File: rtl/ap_match_resolver_if.sv
// ---------------------------------------------------------------------------
// ap_match_resolver_if
// Valid/ready beat port carrying one matched row: {row address, row data}.
//   valid : beat valid (master -> slave)
//   ready : slave accepts the beat (slave -> master)
//   data  : captured row data, DATA_WIDTH bits
//   addr  : row index of data, ADDR_WIDTH_CAM bits
// ---------------------------------------------------------------------------
interface ap_match_resolver_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH_CAM = 8
);

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [ADDR_WIDTH_CAM-1:0] addr;

  modport master (output valid, output data, output addr, input ready);
  modport slave  (input valid, input data, input addr, output ready);

endinterface

// File: rtl/ap_priority_encoder.sv
// ---------------------------------------------------------------------------
// ap_priority_encoder
// Combinational lowest-set-bit finder.
//   vec   : input flag vector, DATA_DEPTH bits
//   idx   : index of the lowest set bit (0 when vec == 0)
//   found : vec != 0
// ---------------------------------------------------------------------------
module ap_priority_encoder #(
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic [DATA_DEPTH-1:0]     vec,
  output logic [ADDR_WIDTH_CAM-1:0] idx,
  output logic                      found
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = ADDR_WIDTH_CAM'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ap_match_resolver.sv
// ---------------------------------------------------------------------------
// ap_match_resolver
// Multiple-response resolver behind the CAM compare output. On start it
// captures tag_row, reports popcount / any-match, then walks the matched rows
// lowest index first, reading each row from the array and streaming
// {row address, row data} on a valid/ready port.
//   clk, rstIn      : clock, synchronous active-low reset
//   start, abort    : walk request (IDLE only) / drop the walk
//   tag_row         : per-row match flags from the array
//   Q_out_row       : row data from the array for addr_output_Row
//   addr_output_Row : registered row address into the array
//   m               : beat output port (valid/ready/data/addr)
//   match_count     : popcount of the captured tag_row
//   any_match       : captured tag_row != 0
//   busy, done      : walk in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module ap_match_resolver
  import ap_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8,
  parameter int CNT_W          = $clog2(DATA_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [DATA_DEPTH-1:0]     tag_row,
  input  logic [DATA_WIDTH-1:0]     Q_out_row,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
  ap_match_resolver_if.master       m,
  output logic [CNT_W-1:0]          match_count,
  output logic                      any_match,
  output logic                      busy,
  output logic                      done
);

  state_t                    state_reg, state_next;
  logic [DATA_DEPTH-1:0]     tag_reg, tag_next;
  logic [ADDR_WIDTH_CAM-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH_CAM-1:0] maddr_reg, maddr_next;
  logic [DATA_WIDTH-1:0]     data_reg, data_next;
  logic                      valid_reg, valid_next;
  logic [CNT_W-1:0]          count_reg, count_next;
  logic                      any_reg, any_next;

  logic [CNT_W-1:0]          pop_count;
  logic [ADDR_WIDTH_CAM-1:0] low_idx;
  logic                      low_found;
  logic [DATA_DEPTH-1:0]     clr_mask;
  logic [DATA_DEPTH-1:0]     tag_cleared;
  logic                      handshake;

  ap_priority_encoder #(
    .DATA_DEPTH     (DATA_DEPTH),
    .ADDR_WIDTH_CAM (ADDR_WIDTH_CAM)
  ) u_enc (
    .vec   (tag_reg),
    .idx   (low_idx),
    .found (low_found)
  );

  // One-hot of the row currently on the output port, used to retire it.
  for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_clr
    assign clr_mask[gi] = (maddr_reg == ADDR_WIDTH_CAM'(gi));
  end

  assign tag_cleared = tag_reg & ~clr_mask;
  assign handshake   = valid_reg & m.ready;

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      pop_count = pop_count + CNT_W'(tag_row[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    tag_next   = tag_reg;
    addr_next  = addr_reg;
    maddr_next = maddr_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    any_next   = any_reg;

    unique case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          tag_next   = tag_row;
          count_next = pop_count;
          any_next   = |tag_row;
          state_next = (|tag_row) ? SCAN : DONE;
        end
      end

      SCAN: begin
        if (abort) begin
          state_next = IDLE;
          tag_next   = '0;
        end else if (low_found) begin
          addr_next  = low_idx;
          maddr_next = low_idx;
          state_next = READ;
        end else begin
          // Unreachable in normal use; finish cleanly rather than stall.
          state_next = DONE;
        end
      end

      READ: begin
        if (abort) begin
          // A concurrent handshake is still an accepted beat; the walk
          // simply ends here, so clearing every remaining bit covers both.
          state_next = IDLE;
          valid_next = 1'b0;
          tag_next   = '0;
        end else if (!valid_reg) begin
          // Entry cycle: the address was registered in SCAN, so Q is stable.
          data_next  = Q_out_row;
          valid_next = 1'b1;
        end else if (handshake) begin
          tag_next   = tag_cleared;
          valid_next = 1'b0;
          state_next = (|tag_cleared) ? SCAN : DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstIn) begin
      state_reg <= IDLE;
      tag_reg   <= '0;
      addr_reg  <= '0;
      maddr_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      count_reg <= '0;
      any_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      tag_reg   <= tag_next;
      addr_reg  <= addr_next;
      maddr_reg <= maddr_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
      any_reg   <= any_next;
    end
  end

  assign addr_output_Row = addr_reg;
  assign m.valid         = valid_reg;
  assign m.data          = data_reg;
  assign m.addr          = maddr_reg;
  assign match_count     = count_reg;
  assign any_match       = any_reg;
  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == DONE);

endmodule

// File: tb/tb_ap_match_resolver.sv
// ---------------------------------------------------------------------------
// tb_ap_match_resolver
// Self-checking bench for ap_match_resolver: directed scenarios plus a
// randomized soak, compared every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_ap_match_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] tag_row = '0;
  logic [7:0]  q_out_row;
  logic [7:0]  addr_out;
  logic        m_ready = 1'b0;
  logic [4:0]  match_count;
  logic        any_match;
  logic        busy;
  logic        done;

  logic [7:0]  row_mem [256];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ap_match_resolver_if #(.DATA_WIDTH(8), .ADDR_WIDTH_CAM(8)) mif ();

  assign mif.ready = m_ready;
  assign q_out_row = row_mem[addr_out];

  ap_match_resolver #(
    .DATA_WIDTH     (8),
    .DATA_DEPTH     (16),
    .ADDR_WIDTH_CAM (8)
  ) dut (
    .clk             (clk),
    .rstIn           (rst_n),
    .start           (start),
    .abort           (abort),
    .tag_row         (tag_row),
    .Q_out_row       (q_out_row),
    .addr_output_Row (addr_out),
    .m               (mif),
    .match_count     (match_count),
    .any_match       (any_match),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Remaining matched rows are a queue, lowest first. After start (or after
  // an accepted beat) the next row is presented two edges later: the first
  // edge puts its address on the array, the second captures the data.
  bit         busy_m = 0, done_m = 0, valid_m = 0, any_m = 0;
  int         gap = 0;
  int         q[$];
  int         cnt_m = 0;
  logic [7:0] addr_m = '0, maddr_m = '0, data_m = '0;

  always @(posedge clk) begin
    bit hs;
    cyc++;
    if (!rst_n) begin
      busy_m = 0; done_m = 0; valid_m = 0; gap = 0; q.delete();
      addr_m = '0; maddr_m = '0; data_m = '0; cnt_m = 0; any_m = 0;
    end else if (!busy_m) begin
      if (start && !abort) begin
        q.delete();
        for (int i = 0; i < 16; i++) if (tag_row[i]) q.push_back(i);
        cnt_m  = q.size();
        any_m  = (q.size() != 0);
        busy_m = 1;
        if (q.size() == 0) done_m = 1; else gap = 2;
      end
    end else if (done_m) begin
      busy_m = 0; done_m = 0;
    end else begin
      hs = valid_m && m_ready;
      if (hs) begin void'(q.pop_front()); valid_m = 0; end
      if (abort) begin
        busy_m = 0; q.delete(); valid_m = 0; gap = 0;
      end else if (hs) begin
        if (q.size() == 0) done_m = 1; else gap = 2;
      end else if (gap == 2) begin
        addr_m = 8'(q[0]); maddr_m = 8'(q[0]); gap = 1;
      end else if (gap == 1) begin
        data_m = row_mem[q[0]]; valid_m = 1; gap = 0;
      end
    end
  end

  // ---------------- compare + logging ----------------
  logic [15:0] beat_log[$];
  int          hs_cyc[$];
  int          done_cyc = -1;
  int          done_cnt = 0;

  always @(negedge clk) begin
    check("busy",            32'(busy),        32'(busy_m));
    check("done",            32'(done),        32'(done_m));
    check("m_valid",         32'(mif.valid),   32'(valid_m));
    check("match_count",     32'(match_count), 32'(cnt_m));
    check("any_match",       32'(any_match),   32'(any_m));
    check("addr_output_Row", 32'(addr_out),    32'(addr_m));
    if (valid_m) begin
      check("m_addr", 32'(mif.addr), 32'(maddr_m));
      check("m_data", 32'(mif.data), 32'(data_m));
    end
    if (rst_n && mif.valid && m_ready) begin
      beat_log.push_back({mif.addr, mif.data});
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_walk(input logic [15:0] t);
    tag_row = t;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) return;
      tick();
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (mif.valid) return;
      tick();
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_valid: m_valid still 0 after %0d cycles", budget);
  endtask

  task automatic clear_logs();
    beat_log.delete();
    hs_cyc.delete();
    done_cyc = -1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] exp_a [4];
    logic [7:0] exp_d [4];
    int         dc;

    for (int r = 0; r < 256; r++) row_mem[r] = 8'h10 + 8'(r);

    // Reset with start held: start must be ignored.
    rst_n = 1'b0; start = 1'b1; tag_row = 16'hFFFF;
    tick(); tick(); tick();
    start = 1'b0; rst_n = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(match_count), 32'd0);
    tick();

    // Reset while a beat is held in READ.
    m_ready = 1'b0;
    start_walk(16'h0003);
    wait_valid(10);
    rst_n = 1'b0; start = 1'b1; tag_row = 16'h00FF;
    tick();
    check("rst_mid_valid", 32'(mif.valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", 32'(addr_out), 32'd0);
    check("rst_mid_count", 32'(match_count), 32'd0);
    tick();
    rst_n = 1'b1; start = 1'b0;
    tick();

    // Zero match: done the cycle right after the start edge.
    clear_logs();
    m_ready = 1'b1;
    start_walk(16'h0000);
    check("zero_done", 32'(done), 32'd1);
    check("zero_any", 32'(any_match), 32'd0);
    check("zero_count", 32'(match_count), 32'd0);
    tick();
    check("zero_done_one_cycle", 32'(done), 32'd0);
    check("zero_no_beats", 32'(beat_log.size()), 32'd0);

    // Sparse match.
    clear_logs();
    start_walk(16'h8421);
    check("sparse_count", 32'(match_count), 32'd4);
    check("sparse_model_count", 32'(cnt_m), 32'd4);
    wait_idle(60);
    exp_a = '{8'd0, 8'd5, 8'd10, 8'd15};
    exp_d = '{8'h10, 8'h15, 8'h1A, 8'h1F};
    check("sparse_nbeats", 32'(beat_log.size()), 32'd4);
    if (beat_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("sparse_beat_addr", 32'(beat_log[i][15:8]), 32'(exp_a[i]));
        check("sparse_beat_data", 32'(beat_log[i][7:0]), 32'(exp_d[i]));
      end
      check("sparse_done_after_last", 32'(done_cyc), 32'(hs_cyc[3] + 1));
    end

    // Backpressure on the first beat.
    clear_logs();
    m_ready = 1'b0;
    start_walk(16'h0006);
    wait_valid(10);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 32'(mif.valid), 32'd1);
      check("bp_hold_addr", 32'(mif.addr), 32'd1);
      check("bp_hold_data", 32'(mif.data), 32'h11);
      tick();
    end
    check("bp_no_beat_yet", 32'(beat_log.size()), 32'd0);
    m_ready = 1'b1;
    wait_idle(30);
    check("bp_nbeats", 32'(beat_log.size()), 32'd2);
    if (beat_log.size() == 2) begin
      check("bp_beat0", 32'(beat_log[0]), 32'h0111);
      check("bp_beat1", 32'(beat_log[1]), 32'h0212);
    end

    // Ignored start mid-walk, then abort during READ.
    clear_logs();
    m_ready = 1'b0;
    start_walk(16'h00F0);
    wait_valid(10);
    start_walk(16'h000F);
    check("ign_start_count", 32'(match_count), 32'd4);
    dc = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(mif.valid), 32'd0);
    check("abort_keeps_count", 32'(match_count), 32'd4);
    tick(); tick();
    check("abort_no_done", 32'(done_cnt), 32'(dc));

    // abort + start together from IDLE.
    abort = 1'b1; start = 1'b1; tag_row = 16'hFFFF;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_start_idle", 32'(busy), 32'd0);
    check("abort_start_count", 32'(match_count), 32'd4);

    // Full match.
    clear_logs();
    m_ready = 1'b1;
    start_walk(16'hFFFF);
    check("full_count", 32'(match_count), 32'h10);
    wait_idle(200);
    check("full_nbeats", 32'(beat_log.size()), 32'd16);
    if (beat_log.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("full_beat_addr", 32'(beat_log[i][15:8]), 32'(i));
      end
    end
    tick();

    // Randomized soak.
    for (int c = 0; c < 3000; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      abort   = ($urandom_range(0, 40) == 0);
      start   = ($urandom_range(0, 5) == 0);
      rst_n   = ($urandom_range(0, 300) != 0);
      if ($urandom_range(0, 3) == 0) tag_row = 16'h0000;
      else tag_row = 16'($urandom()) & 16'($urandom());
      if (!busy_m && $urandom_range(0, 1) == 0)
        row_mem[$urandom_range(0, 15)] = 8'($urandom());
      tick();
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; m_ready = 1'b1;
    wait_idle(200);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
